// File: rtl/arch_regfile.sv
// arch_regfile: architectural register file with rename tags.
// Retires ROB heads in order and writes the committed data into the
// architectural registers. For each register it tracks which ROB tag will
// produce the newest value. It serves two operand lookups, returning either
// the committed value or the pending tag.
//
// Ports:
//   clk, reset (sync, active-low), flush
//   read_num[1:0]   -> read_valid[1:0], read_tag[1:0], read_data[1:0]
//   issue, issue_dest_en, issue_dest, issue_tag
//   commit_valid (out), commit_ready, commit_arch_num, commit_tag, commit_data
//   retire_count    committed instructions since reset (wraps)
module arch_regfile #(
  parameter int REG_WIDTH = 5,
  parameter int ROB_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [1:0][REG_WIDTH-1:0] read_num,
  output logic [1:0]                read_valid,
  output logic [1:0][ROB_WIDTH-1:0] read_tag,
  output logic [1:0][31:0]          read_data,
  input  logic                      issue,
  input  logic                      issue_dest_en,
  input  logic [REG_WIDTH-1:0]      issue_dest,
  input  logic [ROB_WIDTH-1:0]      issue_tag,
  output logic                      commit_valid,
  input  logic                      commit_ready,
  input  logic [REG_WIDTH-1:0]      commit_arch_num,
  input  logic [ROB_WIDTH-1:0]      commit_tag,
  input  logic [31:0]               commit_data,
  output logic [31:0]               retire_count
);

  localparam int NUM_REGS = 1 << REG_WIDTH;

  logic [31:0]          value_q [NUM_REGS];
  logic [ROB_WIDTH-1:0] tag_q   [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;

  logic commit_fire;
  logic commit_clears;

  // The commit handshake never waits on the ROB. A flush drops commit_valid,
  // so nothing retires in the cycle the ROB pointers are cleared.
  assign commit_valid = reset && !flush;
  assign commit_fire  = commit_valid && commit_ready;

  // A commit only releases the register when it is the newest producer.
  // Otherwise a younger in-flight write still owns the register.
  assign commit_clears = commit_fire && busy_q[commit_arch_num] &&
                         (tag_q[commit_arch_num] == commit_tag);

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q       <= '0;
      retire_count <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      if (commit_fire) begin
        value_q[commit_arch_num] <= commit_data;
        retire_count             <= retire_count + 32'd1;
        if (commit_clears) begin
          busy_q[commit_arch_num] <= 1'b0;
        end
      end
      // Placed after the commit so that a same-register issue wins busy/tag.
      if (issue && issue_dest_en) begin
        busy_q[issue_dest] <= 1'b1;
        tag_q[issue_dest]  <= issue_tag;
      end
    end
  end

  // The commit bypass closes the window between the ROB retiring an entry
  // and the busy bit clearing one cycle later.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      read_valid[i] = 1'b1;
      read_tag[i]   = tag_q[read_num[i]];
      read_data[i]  = value_q[read_num[i]];
      if (commit_clears && (commit_arch_num == read_num[i])) begin
        read_data[i] = commit_data;
      end else if (busy_q[read_num[i]]) begin
        read_valid[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arch_regfile.sv
module tb_arch_regfile;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [1:0][4:0]  read_num;
  logic [1:0]       read_valid;
  logic [1:0][2:0]  read_tag;
  logic [1:0][31:0] read_data;
  logic             issue;
  logic             issue_dest_en;
  logic [4:0]       issue_dest;
  logic [2:0]       issue_tag;
  logic             commit_valid;
  logic             commit_ready;
  logic [4:0]       commit_arch_num;
  logic [2:0]       commit_tag;
  logic [31:0]      commit_data;
  logic [31:0]      retire_count;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Reference model: plain arrays holding the architectural state.
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  int          m_tag  [32];
  int unsigned m_retire;

  typedef struct {int dest; int tag;} rob_e;
  rob_e rob_q[$];
  int   next_tag;

  arch_regfile #(.REG_WIDTH(5), .ROB_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .read_num(read_num), .read_valid(read_valid), .read_tag(read_tag),
    .read_data(read_data),
    .issue(issue), .issue_dest_en(issue_dest_en), .issue_dest(issue_dest),
    .issue_tag(issue_tag),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_arch_num(commit_arch_num), .commit_tag(commit_tag),
    .commit_data(commit_data), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; issue = 1'b0; issue_dest_en = 1'b0; issue_dest = '0; issue_tag = '0;
    commit_ready = 1'b0; commit_arch_num = '0; commit_tag = '0; commit_data = '0;
  endtask

  task automatic set_issue(input int d, input int t);
    issue = 1'b1; issue_dest_en = 1'b1; issue_dest = 5'(d); issue_tag = 3'(t);
  endtask

  task automatic set_commit(input int a, input int t, input logic [31:0] d);
    commit_ready = 1'b1; commit_arch_num = 5'(a); commit_tag = 3'(t); commit_data = d;
  endtask

  task automatic set_reads(input int a, input int b);
    read_num[0] = 5'(a); read_num[1] = 5'(b);
  endtask

  // Apply one posedge worth of architectural rules to the model.
  task automatic model_step();
    int c, d;
    c = int'(commit_arch_num);
    d = int'(issue_dest);
    if (!reset) begin
      for (int r = 0; r < 32; r++) begin m_val[r] = 0; m_busy[r] = 0; m_tag[r] = 0; end
      m_retire = 0;
    end else if (flush) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
    end else begin
      if (commit_ready) begin
        m_val[c] = commit_data;
        m_retire = m_retire + 1;
        if (m_busy[c] && m_tag[c] == int'(commit_tag)) m_busy[c] = 0;
      end
      if (issue && issue_dest_en) begin
        m_busy[d] = 1;
        m_tag[d]  = int'(issue_tag);
      end
    end
  endtask

  task automatic exp_read(input int n, output bit v, output int t, output logic [31:0] d);
    bit fire;
    fire = reset && !flush && commit_ready;
    t = m_tag[n];
    d = m_val[n];
    v = 1;
    if (fire && int'(commit_arch_num) == n && m_busy[n] && m_tag[n] == int'(commit_tag))
      d = commit_data;
    else if (m_busy[n])
      v = 0;
  endtask

  task automatic check_all();
    bit v; int t; logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      exp_read(int'(read_num[i]), v, t, d);
      chk($sformatf("port%0d_valid_r%0d", i, read_num[i]), 32'(read_valid[i]), 32'(v));
      if (v) chk($sformatf("port%0d_data_r%0d", i, read_num[i]), read_data[i], d);
      else   chk($sformatf("port%0d_tag_r%0d", i, read_num[i]), 32'(read_tag[i]), 32'(t));
    end
    chk("commit_valid", 32'(commit_valid), 32'(reset && !flush));
    chk("retire_count", retire_count, m_retire);
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    bit fl;
    reset = 1'b0;
    idle();
    set_reads(3, 31);
    @(posedge clk);
    model_step();
    #1;

    // Reset state
    chk("rst_valid0", 32'(read_valid[0]), 1);
    chk("rst_valid1", 32'(read_valid[1]), 1);
    chk("rst_data0", read_data[0], 0);
    chk("rst_data1", read_data[1], 0);
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_retire", retire_count, 0);
    tick();
    reset = 1'b1;
    #1 chk("commit_valid_after_release", 32'(commit_valid), 1);
    tick();

    // Issue then commit with same-cycle bypass
    set_issue(5, 2);
    tick();
    idle(); set_reads(5, 5);
    #1 chk("r5_pending_valid", 32'(read_valid[0]), 0);
    chk("r5_pending_tag", 32'(read_tag[0]), 2);
    tick();
    set_commit(5, 2, 32'hDEADBEEF);
    #1 chk("r5_bypass_valid", 32'(read_valid[1]), 1);
    chk("r5_bypass_data", read_data[1], 32'hDEADBEEF);
    tick();
    idle();
    #1 chk("r5_after_valid", 32'(read_valid[0]), 1);
    chk("r5_after_data", read_data[0], 32'hDEADBEEF);
    chk("retire_one", retire_count, 1);
    tick();

    // Older commit must not clear a younger producer
    set_issue(7, 1); tick();
    idle(); set_issue(7, 4); tick();
    idle(); set_commit(7, 1, 32'h11); set_reads(7, 7); tick();
    idle();
    #1 chk("r7_still_busy", 32'(read_valid[0]), 0);
    chk("r7_young_tag", 32'(read_tag[0]), 4);
    tick();
    set_commit(7, 4, 32'h44); tick();
    idle();
    #1 chk("r7_final_valid", 32'(read_valid[0]), 1);
    chk("r7_final_data", read_data[0], 32'h44);
    tick();

    // Same-cycle issue and commit to one register
    set_issue(9, 3); tick();
    idle(); set_issue(9, 6); set_commit(9, 3, 32'h33); set_reads(9, 9); tick();
    idle();
    #1 chk("r9_issue_wins_valid", 32'(read_valid[0]), 0);
    chk("r9_issue_wins_tag", 32'(read_tag[0]), 6);
    tick();

    // Flush
    set_issue(2, 0); tick();
    idle(); set_issue(4, 1); tick();
    idle(); set_issue(6, 2); tick();
    idle(); flush = 1'b1; set_issue(8, 3); set_commit(2, 0, 32'h0BAD); set_reads(2, 4);
    #1 chk("flush_commit_valid", 32'(commit_valid), 0);
    tick();
    idle();
    #1 chk("flush_r2_valid", 32'(read_valid[0]), 1);
    chk("flush_r2_data", read_data[0], 0);
    chk("flush_r4_valid", 32'(read_valid[1]), 1);
    chk("flush_retire_held", retire_count, 4);
    tick();
    set_reads(6, 8);
    #1 chk("flush_r6_valid", 32'(read_valid[0]), 1);
    chk("flush_r8_valid", 32'(read_valid[1]), 1);
    tick();
    set_reads(9, 7);
    #1 chk("flush_r9_value", read_data[0], 32'h33);
    chk("flush_r7_value", read_data[1], 32'h44);
    tick();

    // Mid-operation reset with activity pending
    reset = 1'b0; set_issue(12, 5); set_commit(7, 0, 32'h77); tick();
    reset = 1'b1; idle(); set_reads(7, 12);
    #1 chk("midrst_retire", retire_count, 0);
    chk("midrst_r7_data", read_data[0], 0);
    tick();

    // 40 back-to-back commits with tags wrapping
    for (int i = 0; i < 40; i++) begin
      idle();
      if (i == 0) set_commit(20, 0, 32'h1000);
      else        set_commit(10 + (i - 1) % 8, (i - 1) % 8, 32'h1000 + 32'(i));
      if (i < 39) set_issue(10 + i % 8, i % 8);
      set_reads(10 + (i + 3) % 8, 10 + (i + 7) % 8);
      tick();
    end
    idle();
    #1 chk("retire_forty", retire_count, 40);
    for (int k = 0; k < 16; k++) begin
      set_reads(2 * k, 2 * k + 1);
      #1 chk($sformatf("nobusy_r%0d", 2 * k), 32'(read_valid[0]), 1);
      chk($sformatf("nobusy_r%0d", 2 * k + 1), 32'(read_valid[1]), 1);
      tick();
    end

    // Randomized traffic from an in-order ROB model
    rob_q.delete();
    next_tag = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      fl = ($urandom_range(0, 24) == 0);
      flush = fl;
      if (rob_q.size() < 8 && $urandom_range(0, 2) != 0) begin
        issue = 1'b1;
        issue_dest_en = ($urandom_range(0, 3) != 0);
        issue_dest = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        issue_tag = 3'(next_tag);
      end
      if (rob_q.size() > 0 && $urandom_range(0, 1) == 1)
        set_commit(rob_q[0].dest, rob_q[0].tag, $urandom());
      set_reads(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                (rob_q.size() > 0) ? rob_q[0].dest : $urandom_range(0, 7));
      tick();
      if (fl) begin
        rob_q.delete();
        next_tag = 0;
      end else begin
        if (commit_ready) void'(rob_q.pop_front());
        if (issue && issue_dest_en) begin
          rob_q.push_back('{dest: int'(issue_dest), tag: next_tag});
          next_tag = (next_tag + 1) % 8;
        end
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/arch_regfile.md
# arch_regfile

Architectural register file with rename tags, sitting directly downstream of the reorder buffer. It retires ROB heads in order by driving the commit handshake and writing committed data into the architectural registers. It records, per register, which ROB tag will produce the newest value and answers the issue stage's two operand lookups with either a committed value or a pending tag. The issue stage then resolves a pending tag through the ROB's read ports.

## Interface

Parameters:
- REG_WIDTH, 5, log2 of architectural register count (32 registers)
- ROB_WIDTH, 3, log2 of ROB depth; width of rename tags

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-low; state cleared on any posedge with reset==0
- flush  in  1  discard speculation; asserted in the same cycle the ROB pointers are cleared
- read_num[1:0]  in  REG_WIDTH each  operand register numbers
- read_valid[1:0]  out  1 each  1 = read_data holds the architectural value; 0 = value pending in ROB
- read_tag[1:0]  out  ROB_WIDTH each  producing ROB tag; meaningful only when read_valid==0
- read_data[1:0]  out  32 each  register value; meaningful only when read_valid==1
- issue  in  1  an instruction is issued this cycle
- issue_dest_en  in  1  the issued instruction writes a register
- issue_dest  in  REG_WIDTH  destination register
- issue_tag  in  ROB_WIDTH  ROB tag allocated to the issued instruction
- commit_valid  out  1  consumer side of the ROB commit handshake (commit_req.valid)
- commit_ready  in  1  ROB head entry is complete (commit_req.ready)
- commit_arch_num  in  REG_WIDTH  destination of the ROB head
- commit_tag  in  ROB_WIDTH  tag of the ROB head
- commit_data  in  32  result of the ROB head
- retire_count  out  32  number of committed instructions since reset

## Operation

Per-register state:
- value[31:0], reset 0
- busy, reset 0
- tag[ROB_WIDTH-1:0], reset 0

Commit handshake:
- commit_valid = reset && !flush. It is combinational and never waits on commit_ready.
- A commit fires when commit_valid && commit_ready.

On a commit fire, with r = commit_arch_num:
- value[r] <= commit_data.
- If busy[r] && tag[r]==commit_tag, then busy[r] <= 0. Otherwise busy is untouched, because a younger producer is still in flight.
- retire_count <= retire_count + 1, wrapping modulo 2^32.

On issue && issue_dest_en, with d = issue_dest:
- busy[d] <= 1 and tag[d] <= issue_tag.
- If issue and commit target the same register in the same cycle, the issue wins for busy and tag. The committed value is still written.

Flush (flush==1, reset==1):
- All busy bits are cleared.
- Any issue in that cycle is ignored.
- value and retire_count are held.

Reads are combinational, per port i with n = read_num[i]:
- Commit bypass: if a commit fires this cycle with commit_arch_num==n, busy[n]==1 and tag[n]==commit_tag, then read_valid=1 and read_data=commit_data.
- Pending: else if busy[n]==1, then read_valid=0 and read_tag=tag[n].
- Committed: else read_valid=1 and read_data=value[n].
- Reads never see same-cycle issue updates. The issue stage handles intra-bundle dependencies itself.

Other rules:
- Register 0 is an ordinary register with no hardwired zero.
- Priority on a posedge: reset==0, then flush, then commit/issue.

## Timing

- Issue and commit effects on state become visible on the cycle after the posedge.
- Commit-to-read has 0-cycle latency via the bypass, so no wakeup can be lost between the ROB clearing an entry and the register becoming non-busy.
- One commit per cycle at most; throughput is 1 retire per cycle while commit_ready stays high.
- Tag wrap-around: ROB tags repeat modulo 2^ROB_WIDTH. Correctness relies on the ROB never issuing into an occupied entry. A stale tag match therefore cannot occur while busy is set.

Reset values of outputs (while reset==0):
- commit_valid = 0
- retire_count = 0
- read outputs reflect cleared state: read_valid = 1, read_data = 0

Reset mid-operation: all state clears on the next posedge regardless of issue, commit or flush.

## Test plan

- Reset, then read registers 3 and 31 -> read_valid=1 and read_data=0 on both ports; commit_valid=0 while reset==0 and 1 after release.
- Issue dest=5, tag=2; next cycle read 5 -> valid=0, tag=2. Then commit_ready=1, arch=5, tag=2, data=0xDEADBEEF -> the same-cycle read shows valid=1, data=0xDEADBEEF; the next cycle shows busy clear and retire_count=1.
- Issue dest=7 with tag=1, then dest=7 with tag=4; commit tag=1 with data=0x11 -> reg 7 stays busy with tag=4 while value=0x11; committing tag=4 with data=0x44 -> read gives 0x44.
- Same cycle: issue dest=9 with tag=6 and commit arch=9, tag=3, data=0x33 (reg 9 busy with tag=3) -> next cycle busy=1, tag=6, value=0x33.
- Issue dest=2, 4 and 6; assert flush together with issue dest=8 and commit_ready=1 -> commit_valid=0 in that cycle, no retire_count increment, and all of 2, 4, 6 and 8 read valid with their old values.
- Hold commit_ready=1 for 40 cycles with tags cycling 0..7 -> retire_count=40, and tag wrap produces no stray busy bits.
